// File: rtl/flag_stack_pkg.sv
// Shared types and defaults for the flip/flag save-restore stack.
package flag_stack_pkg;

  typedef struct packed {
    logic flip;
    logic flag;
  } flag_pair_t;

  localparam int FLAG_STACK_DEPTH_DEFAULT = 8;

endpackage

// File: rtl/flag_stack_if.sv
// Control-side signal bundle of flag_stack; master = control unit, slave = stack.
interface flag_stack_if
  import flag_stack_pkg::*;
#(
  parameter int DEPTH = FLAG_STACK_DEPTH_DEFAULT
);
  localparam int PTR_W = $clog2(DEPTH);

  logic           push;
  logic           pop;
  logic           flipcur;
  logic           flagcur;
  logic           errClr;
  logic           flipRestore;
  logic           flagRestore;
  logic           writeFlipRestore;
  logic           writeFlagRestore;
  logic [PTR_W:0] count;
  logic           full;
  logic           empty;
  logic           err;

  modport master (
    output push, pop, flipcur, flagcur, errClr,
    input  flipRestore, flagRestore, writeFlipRestore, writeFlagRestore,
    input  count, full, empty, err
  );

  modport slave (
    input  push, pop, flipcur, flagcur, errClr,
    output flipRestore, flagRestore, writeFlipRestore, writeFlagRestore,
    output count, full, empty, err
  );

endinterface

// File: rtl/flag_stack_mem.sv
// DEPTH x flag_pair_t register array: one synchronous write port, one async read port, no reset.
module flag_stack_mem
  import flag_stack_pkg::*;
#(
  parameter int DEPTH = FLAG_STACK_DEPTH_DEFAULT,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  flag_pair_t    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output flag_pair_t    o_rdata
);

  flag_pair_t r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/flag_stack.sv
// LIFO save/restore for the flip/flag register pair.
// Optional sticky overflow/underflow flag enabled by defining FLAG_STACK_ERR_EN.
module flag_stack
  import flag_stack_pkg::*;
#(
  parameter int DEPTH = FLAG_STACK_DEPTH_DEFAULT
) (
  input logic          CLK,
  input logic          RSTn,
  flag_stack_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]   r_sp;
  logic [PTR_W:0]   w_sp_dec;
  logic [PTR_W-1:0] w_waddr;
  logic             w_full;
  logic             w_empty;
  logic             w_pop_ok;
  logic             w_push_ok;
  logic             w_ovf;
  logic             w_udf;
  flag_pair_t       w_wdata;
  flag_pair_t       w_rdata;
  flag_pair_t       r_restore;
  logic             r_strobe;

  assign w_full   = (r_sp == (PTR_W+1)'(DEPTH));
  assign w_empty  = (r_sp == '0);
  assign w_sp_dec = r_sp - (PTR_W+1)'(1);

  // A push while full still succeeds when paired with a pop: it is an exchange of the top slot.
  assign w_pop_ok  = bus.pop && !w_empty;
  assign w_push_ok = bus.push && (!w_full || w_pop_ok);
  assign w_ovf     = bus.push && !w_push_ok;
  assign w_udf     = bus.pop && w_empty;

  assign w_waddr = w_pop_ok ? w_sp_dec[PTR_W-1:0] : r_sp[PTR_W-1:0];
  assign w_wdata = '{flip: bus.flipcur, flag: bus.flagcur};

  flag_stack_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .i_clk   (CLK),
    .i_we    (w_push_ok),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_sp_dec[PTR_W-1:0]),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_sp <= '0;
    end else if (w_push_ok && !w_pop_ok) begin
      r_sp <= r_sp + (PTR_W+1)'(1);
    end else if (w_pop_ok && !w_push_ok) begin
      r_sp <= w_sp_dec;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_restore <= '0;
      r_strobe  <= 1'b0;
    end else begin
      r_strobe <= w_pop_ok;
      if (w_pop_ok) r_restore <= w_rdata;
    end
  end

  assign bus.flipRestore      = r_restore.flip;
  assign bus.flagRestore      = r_restore.flag;
  assign bus.writeFlipRestore = r_strobe;
  assign bus.writeFlagRestore = r_strobe;
  assign bus.count            = r_sp;
  assign bus.full             = w_full;
  assign bus.empty            = w_empty;

`ifdef FLAG_STACK_ERR_EN
  logic r_err;

  // A new event wins over a simultaneous clear.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_err <= 1'b0;
    end else if (w_ovf || w_udf) begin
      r_err <= 1'b1;
    end else if (bus.errClr) begin
      r_err <= 1'b0;
    end
  end

  assign bus.err = r_err;
`else
  logic w_unused;
  assign w_unused = ^{w_ovf, w_udf, bus.errClr};
  assign bus.err  = 1'b0;
`endif

endmodule

// File: doc/flag_stack.md
# flag_stack

Save/restore LIFO for the processor's single-bit `flip` and `flag` state registers. It captures the live register outputs on a push (call/interrupt entry). On a pop (return) it drives the registers' data-in and write-enable inputs to restore the saved pair. It sits beside the single-bit register pair in the single-cycle CPU: it reads their outputs and is the second writer of their inputs, muxed with the ALU path by the control unit.

## Interface
Parameters:
- DEPTH, 8, number of saved {flip,flag} entries; power of two, ≥2
- PTR_W, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
- CLK  input  1  clock; all state updates on posedge
- RSTn  input  1  reset, asynchronous, active-low
- push  input  1  save current {flipcur,flagcur}
- pop  input  1  restore most recent entry
- flipcur  input  1  live flip register output
- flagcur  input  1  live flag register output
- errClr  input  1  clears sticky err
- flipRestore  output  1  restore value for flip
- flagRestore  output  1  restore value for flag
- writeFlipRestore  output  1  one-cycle write strobe for flip
- writeFlagRestore  output  1  one-cycle write strobe for flag
- count  output  PTR_W+1  occupied entries, 0..DEPTH
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- err  output  1  sticky overflow/underflow indicator

## Operation
- Stack pointer `sp` (PTR_W+1 bits) equals count.
- Push accepted when !full:
  - mem[sp] <= {flipcur,flagcur}
  - sp <= sp+1
- Pop accepted when !empty:
  - {flipRestore,flagRestore} <= mem[sp-1]
  - both strobes <= 1
  - sp <= sp-1
- Push and pop in the same cycle, !empty (exchange):
  - restore outputs <= mem[sp-1]
  - mem[sp-1] <= {flipcur,flagcur}
  - strobes pulse; sp unchanged
- Push and pop in the same cycle, empty: pop is an underflow and is ignored; push is accepted normally.
- Push when full: ignored, memory and sp unchanged, overflow event.
- Pop when empty: ignored, strobes stay 0, restore values hold, underflow event.
- Strobes are single-cycle pulses. Both strobes always assert together. Restore values hold their last popped value between pops.
- Entries are not range-reduced: the pointer never wraps. Boundary cases are blocked by the full/empty checks.

## Timing
- Reset (RSTn low, asynchronous):
  - sp=0, count=0, empty=1, full=0
  - flipRestore=0, flagRestore=0, both strobes=0, err=0
  - memory contents not reset
- Reset asserted mid-operation discards all entries. A strobe pending for the next edge is cancelled.
- count, full and empty are combinational from sp and update on the edge that accepts push or pop.
- Restore outputs and strobes are registered: valid in the cycle after the accepted pop.
- Flip/flag registers take the restored value on the following edge: 2 edges from pop to visible state.
- A push in the cycle immediately after a pop samples the pre-restore flipcur/flagcur. The control unit must not push during a restore strobe cycle.

## Configuration
- FLAG_STACK_ERR_EN defined:
  - err sets on the edge after any overflow or underflow event
  - err holds until errClr or reset
  - errClr and a new event in the same cycle: err stays set
- FLAG_STACK_ERR_EN undefined: err is tied 0, errClr is ignored, no error register is synthesized. Push/pop ignore rules are unchanged.

## Structure
- Package flag_stack_pkg holds:
  - typedef struct packed {logic flip; logic flag;} flag_pair_t
  - localparam FLAG_STACK_DEPTH_DEFAULT = 8
- Sub-module flag_stack_mem: DEPTH×flag_pair_t register array with one write port and one async read port, no reset.
- The top level holds sp, the accept logic, the restore registers and err.

## Test plan
- Reset, then 3 pushes of {1,0},{0,1},{1,1} -> count=3, empty=0; then 3 pops -> strobes pulse each cycle after pop, restore sequence {1,1},{0,1},{1,0}; count=0, empty=1.
- DEPTH=8: 9 pushes -> full=1 after the 8th, 9th ignored, count=8, err=1 with macro and 0 without; pop -> restore = 8th pushed value.
- Pop on empty after reset -> strobes stay 0, count=0, err=1 with macro; errClr -> err=0 next cycle.
- Push {0,0}, then push+pop with cur={1,1} -> restore {0,0} strobed, count=1; pop -> restore {1,1}.
- Push+pop on empty with cur={1,0} -> count=1, no strobe, err=1 with macro.
- RSTn pulsed low mid-cycle while count=2 and a pop is in flight -> outputs immediately at reset values, no strobe on the next edge, count=0.
